instr_mem_responder: RTL
========================

# instr_mem_responder

Instruction-memory responder that sits on the far side of the fetch interface. It accepts one word-fetch request at a time from the instruction-fetch stage and returns the 32-bit instruction after a fixed, parameterised latency, asserting busy while a request is outstanding. It discards in-flight requests on a branch/jump flush and substitutes a NOP with a fault flag for misaligned or out-of-range addresses. It carries a word-write load port so the testbench or boot logic can fill the array.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-index bits; array holds 2**ADDR_WIDTH words.
- LATENCY, 2: cycles from request acceptance to fetch_valid; legal range 1..15.
- NOP_WORD, 32'h00000013: word returned on fault (addi x0,x0,0).

Ports:
- CLK, input, 1: single clock; all state updates on rising edge.
- RESET, input, 1: synchronous, active-high reset.
- fetch_req, input, 1: request strobe from the fetch stage.
- fetch_addr, input, 32: byte address (PC) of requested word.
- fetch_flush, input, 1: branch/jump taken; cancel any outstanding request.
- fetch_busy, output, 1: request outstanding; a new fetch_req is not accepted.
- fetch_valid, output, 1: fetch_instr/fetch_fault valid this cycle (one-cycle pulse).
- fetch_instr, output, 32: returned instruction word.
- fetch_fault, output, 1: returned word was NOP_WORD due to misaligned or out-of-range address.
- load_en, input, 1: array write strobe.
- load_addr, input, ADDR_WIDTH: word index to write.
- load_data, input, 32: word to write.

## Operation
- States: IDLE, WAIT, RESP.
- Acceptance: fetch_req=1, fetch_busy=0 and fetch_flush=0 at an edge. The block captures fetch_addr and loads the latency counter with LATENCY-1.
  - LATENCY=1: next state RESP.
  - LATENCY≥2: next state WAIT.
- WAIT: counter decrements each cycle. When the counter reaches 1, the next state is RESP and the read result is registered at that edge.
- RESP: fetch_valid=1 for exactly one cycle and fetch_busy=0. A request presented in RESP is accepted, giving back-to-back operation at one response per LATENCY cycles. If no request is accepted, the next state is IDLE.
- Address checks on the captured address:
  - Misaligned: addr[1:0]≠0.
  - Out of range: addr[31:ADDR_WIDTH+2]≠0.
  - Either condition sets fetch_instr=NOP_WORD and fetch_fault=1.
  - Otherwise fetch_instr=array[addr[ADDR_WIDTH+1:2]] and fetch_fault=0.
- fetch_instr and fetch_fault are registered. They hold their last value until the next response is registered.
- Flush:
  - fetch_flush=1 in any cycle forces the next state to IDLE and cancels the outstanding request.
  - In RESP, fetch_valid is masked to 0 combinationally while fetch_flush=1.
  - A simultaneous fetch_req is not accepted; flush wins.
- Load:
  - The write occurs at the edge when load_en=1 and fetch_busy=0.
  - It is ignored while busy; no queuing.
  - A load and an accepted fetch to the same word in the same cycle returns the new data, because the array read occurs at a later edge.
- Array contents are not affected by RESET.

## Timing
- Reset values, one edge after RESET=1: state IDLE, fetch_busy=0, fetch_valid=0, fetch_instr=32'h0, fetch_fault=0, counter=0. Reset mid-WAIT or mid-RESP drops the request with no valid pulse.
- Request accepted at edge k:
  - fetch_valid=1 during cycle k+LATENCY only.
  - fetch_busy=1 during cycles k+1 … k+LATENCY-1 (never for LATENCY=1).
- fetch_busy is a function of state only (WAIT → 1). It has no combinational path from fetch_req.
- fetch_valid depends combinationally on state and fetch_flush only.
- Counter width is 4 bits.

## Test plan
- Reset, then load word0=0x00500093 and word1=0x00100113. With LATENCY=2, request addr 0x0 at edge k → busy=1 in k+1; valid=1 in k+2 with instr=0x00500093 and fault=0; valid=0 in k+3.
- In the valid cycle k+2, request addr 0x4 → valid at k+4 with 0x00100113. With no further request, state returns to IDLE and busy=0.
- Request addr 0x6 → valid at k+2 with instr=0x00000013 and fault=1. Request addr 0x400 (ADDR_WIDTH=8) → same NOP with fault=1.
- Accept addr 0x0, assert fetch_flush at k+1 → no valid pulse at k+2 and busy=0 at k+2. A request at k+2 is accepted; valid at k+4.
- Assert fetch_flush in the RESP cycle → fetch_valid=0 that cycle. A simultaneous fetch_req is not accepted.
- Assert RESET during WAIT → next cycle all outputs at reset values and no valid pulse. Then assert load_en while busy with word0=0xDEADBEEF → write ignored; a later fetch of addr 0 returns the original word.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: one outstanding word fetch, fixed LATENCY response,
// flush cancellation, NOP+fault for bad addresses, and a word-write load port.
module instr_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_busy,
    output logic                  fetch_valid,
    output logic [31:0]           fetch_instr,
    output logic                  fetch_fault,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           instr_q, instr_d;
    logic                  fault_q, fault_d;
    logic [31:0]           mem_q [2**ADDR_WIDTH];

    logic                  accept;
    logic                  mem_we;
    logic                  resp_load;
    logic [31:0]           rd_addr;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [31:0]           rd_word;
    logic                  rd_bad;

    assign fetch_busy  = (state_q == WAIT);
    assign fetch_valid = (state_q == RESP) && !fetch_flush;
    assign fetch_instr = instr_q;
    assign fetch_fault = fault_q;
    assign accept      = fetch_req && !fetch_busy && !fetch_flush;
    assign mem_we      = load_en && !fetch_busy;

    // Same-cycle load forwarding only matters for LATENCY=1, where the read
    // happens at the acceptance edge itself.
    assign rd_idx  = rd_addr[ADDR_WIDTH+1:2];
    assign rd_word = (mem_we && load_addr == rd_idx) ? load_data : mem_q[rd_idx];
    assign rd_bad  = (rd_addr[1:0] != 2'b00) || ((rd_addr >> (ADDR_WIDTH + 2)) != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        fault_d   = fault_q;
        resp_load = 1'b0;
        rd_addr   = addr_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d = fetch_addr;
                    cnt_d  = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        rd_addr   = fetch_addr;
                        resp_load = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d   = RESP;
                    resp_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fetch_flush) begin
            state_d   = IDLE;
            resp_load = 1'b0;
        end
        if (resp_load) begin
            instr_d = rd_bad ? NOP_WORD : rd_word;
            fault_d = rd_bad;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Array is deliberately outside reset so boot contents survive RESET.
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[load_addr] <= load_data;
    end

endmodule
